// File: rtl/vga_ram_write_arbiter.sv
// Arbitrates two pixel-write requesters onto the VGA RAM write port, blank window only.
// Latency: ram_we rises the cycle after a transfer and stays high for WR_CYCLES cycles.
// Backpressure: reqN_ready is low outside blank, while a write/clear is in flight, or when the other requester holds the grant.
//
// Ports: clk, rst (async active-high), blank (write window open),
//        req0_*/req1_* valid/ready/x/y/data requester handshakes,
//        clear_start/clear_busy (framebuffer clear, only with `define VGA_CLEAR_EN),
//        ram_we/ram_x/ram_y/ram_wdata to the RAM write port, err_drop (out-of-range discard pulse).
// Optional feature macro: VGA_CLEAR_EN (full-framebuffer clear sweep).
module vga_ram_write_arbiter #(
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int WR_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           blank,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [X_W-1:0] req0_x,
  input  logic [Y_W-1:0] req0_y,
  input  logic           req0_data,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [X_W-1:0] req1_x,
  input  logic [Y_W-1:0] req1_y,
  input  logic           req1_data,
  input  logic           clear_start,
  output logic           clear_busy,
  output logic           ram_we,
  output logic [X_W-1:0] ram_x,
  output logic [Y_W-1:0] ram_y,
  output logic           ram_wdata,
  output logic           err_drop
);

  localparam logic [X_W-1:0] X_LAST  = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(Y_MAX);
  localparam logic [1:0]     WR_LAST = 2'(WR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE
`ifdef VGA_CLEAR_EN
    , CLEAR
`endif
  } state_t;

  state_t     state;
  logic       last;      // requester granted most recently
  logic [1:0] wr_cnt;    // ram_we cycles already spent in WRITE
  logic       sel;
  logic       clr_req;
  logic       accept;
  logic       xfer;
  logic [X_W-1:0] x_in;
  logic [Y_W-1:0] y_in;
  logic       d_in;
  logic       in_range;

`ifdef VGA_CLEAR_EN
  logic clr_busy_q;
  assign clr_req    = clear_start;
  assign clear_busy = clr_busy_q;
`else
  logic clear_start_unused;
  assign clear_start_unused = clear_start;
  assign clr_req    = 1'b0;
  assign clear_busy = 1'b0;
`endif

  // Sole valid requester wins; on contention the one not granted last wins.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last;
    else if (req1_valid)          sel = 1'b1;
  end

  // A clear request in the same cycle pre-empts any pixel transfer.
  assign accept     = (state == IDLE) && blank && !clr_req;
  assign req0_ready = accept && req0_valid && !sel;
  assign req1_ready = accept && req1_valid &&  sel;
  assign xfer       = req0_ready || req1_ready;

  assign x_in     = sel ? req1_x    : req0_x;
  assign y_in     = sel ? req1_y    : req0_y;
  assign d_in     = sel ? req1_data : req0_data;
  assign in_range = (x_in <= X_LAST) && (y_in <= Y_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      wr_cnt    <= 2'd0;
      ram_we    <= 1'b0;
      ram_x     <= '0;
      ram_y     <= '0;
      ram_wdata <= 1'b0;
      err_drop  <= 1'b0;
`ifdef VGA_CLEAR_EN
      clr_busy_q <= 1'b0;
`endif
    end else begin
      err_drop <= 1'b0;
      case (state)
        IDLE: begin
`ifdef VGA_CLEAR_EN
          if (clear_start) begin
            // First pixel (0,0) goes out next cycle if the window is open.
            state      <= CLEAR;
            clr_busy_q <= 1'b1;
            ram_we     <= blank;
            ram_x      <= '0;
            ram_y      <= '0;
            ram_wdata  <= 1'b0;
          end else
`endif
          if (xfer) begin
            ram_x     <= x_in;
            ram_y     <= y_in;
            ram_wdata <= d_in;
            last      <= sel;
            if (in_range) begin
              state  <= WRITE;
              ram_we <= 1'b1;
              wr_cnt <= 2'd0;
            end else begin
              err_drop <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Runs to completion even if blank drops mid-write.
          if (wr_cnt == WR_LAST) begin
            ram_we <= 1'b0;
            state  <= IDLE;
          end else begin
            wr_cnt <= wr_cnt + 2'd1;
          end
        end
`ifdef VGA_CLEAR_EN
        CLEAR: begin
          // ram_x/ram_y double as the sweep counters; they only advance once
          // the pixel they address has actually been written.
          if (ram_we) begin
            if (ram_x == X_LAST && ram_y == Y_LAST) begin
              state      <= IDLE;
              clr_busy_q <= 1'b0;
              ram_we     <= 1'b0;
              ram_x      <= '0;
              ram_y      <= '0;
            end else begin
              ram_we <= blank;
              if (ram_x == X_LAST) begin
                ram_x <= '0;
                ram_y <= ram_y + 1'b1;
              end else begin
                ram_x <= ram_x + 1'b1;
              end
            end
          end else begin
            ram_we <= blank;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_ram_write_arbiter.sv
// Directed bench for vga_ram_write_arbiter: a WR_CYCLES=1 instance and a WR_CYCLES=3
// instance share all inputs; each section resets both before use.
// Inputs change on the falling edge; outputs are checked on the falling edge or #1 after it.
module tb_vga_ram_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       blank;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_x, req1_x;
  logic [9:0] req0_y, req1_y;
  logic       req0_data, req1_data;
  logic       clear_start;

  logic       req0_ready, req1_ready, clear_busy, ram_we, ram_wdata, err_drop;
  logic [9:0] ram_x, ram_y;
  logic       w3_req0_ready, w3_req1_ready, w3_clear_busy, w3_we, w3_wdata, w3_err_drop;
  logic [9:0] w3_x, w3_y;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_ram_write_arbiter #(.WR_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .blank(blank),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_data(req1_data),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .ram_we(ram_we), .ram_x(ram_x), .ram_y(ram_y), .ram_wdata(ram_wdata), .err_drop(err_drop)
  );

  vga_ram_write_arbiter #(.WR_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .blank(blank),
    .req0_valid(req0_valid), .req0_ready(w3_req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(w3_req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_data(req1_data),
    .clear_start(clear_start), .clear_busy(w3_clear_busy),
    .ram_we(w3_we), .ram_x(w3_x), .ram_y(w3_y), .ram_wdata(w3_wdata), .err_drop(w3_err_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; clear_start = 0;
    req0_x = 0; req0_y = 0; req0_data = 0;
    req1_x = 0; req1_y = 0; req1_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; blank = 0;
    idle_inputs();
    @(negedge clk);

    // ---- reset values ----
    chk("rst_we", ram_we, 0);
    chk("rst_x", ram_x, 0);
    chk("rst_y", ram_y, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_err", err_drop, 0);
    chk("rst_busy", clear_busy, 0);
    rst = 0;

    // ---- single write ----
    blank = 1; req0_valid = 1; req0_x = 130; req0_y = 50; req0_data = 1;
    #1;
    chk("single_rdy0", req0_ready, 1);
    chk("single_rdy1", req1_ready, 0);
    step();
    req0_valid = 0;
    chk("single_we", ram_we, 1);
    chk("single_x", ram_x, 130);
    chk("single_y", ram_y, 50);
    chk("single_wdata", ram_wdata, 1);
    step();
    chk("single_we_off", ram_we, 0);
    chk("single_x_hold", ram_x, 130);

    // ---- contention: grants 0,1,0,1 with a write every second cycle ----
    do_reset();
    blank = 1;
    req0_valid = 1; req0_x = 1; req0_y = 11; req0_data = 1;
    req1_valid = 1; req1_x = 2; req1_y = 22; req1_data = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk("cont_rdy0", req0_ready, ((i / 2) % 2 == 0) ? 1 : 0);
        chk("cont_rdy1", req1_ready, ((i / 2) % 2 == 1) ? 1 : 0);
        chk("cont_we_lo", ram_we, 0);
      end else begin
        chk("cont_we_hi", ram_we, 1);
        chk("cont_x", ram_x, (((i - 1) / 2) % 2 == 0) ? 1 : 2);
        chk("cont_wdata", ram_wdata, (((i - 1) / 2) % 2 == 0) ? 1 : 0);
        chk("cont_busy_rdy0", req0_ready, 0);
      end
      step();
    end

    // ---- blank gating ----
    do_reset();
    blank = 0;
    req1_valid = 1; req1_x = 5; req1_y = 6; req1_data = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("gate_rdy1", req1_ready, 0);
      chk("gate_we", ram_we, 0);
      step();
    end
    blank = 1;
    #1;
    chk("gate_rdy1_open", req1_ready, 1);
    step();
    req1_valid = 0;
    chk("gate_we_hi", ram_we, 1);
    chk("gate_x", ram_x, 5);
    chk("gate_y", ram_y, 6);
    step();

    // ---- out of range: x, then y, then the last valid pixel ----
    req0_valid = 1; req0_x = 640; req0_y = 10; req0_data = 1;
    #1;
    chk("oor_x_rdy0", req0_ready, 1);
    step();
    req0_valid = 0;
    chk("oor_x_err", err_drop, 1);
    chk("oor_x_we", ram_we, 0);
    step();
    chk("oor_x_err_clr", err_drop, 0);
    chk("oor_x_we2", ram_we, 0);
    req0_valid = 1; req0_x = 10; req0_y = 480;
    #1;
    chk("oor_y_rdy0", req0_ready, 1);
    step();
    req0_valid = 0;
    chk("oor_y_err", err_drop, 1);
    chk("oor_y_we", ram_we, 0);
    step();
    req0_valid = 1; req0_x = 639; req0_y = 479; req0_data = 0;
    step();
    req0_valid = 0;
    chk("edge_err", err_drop, 0);
    chk("edge_we", ram_we, 1);
    chk("edge_x", ram_x, 639);
    chk("edge_y", ram_y, 479);
    step();

`ifndef VGA_CLEAR_EN
    // ---- clear_start has no effect without the clear feature ----
    clear_start = 1; req0_valid = 1; req0_x = 3; req0_y = 4; req0_data = 1;
    #1;
    chk("noclr_rdy0", req0_ready, 1);
    step();
    clear_start = 0; req0_valid = 0;
    chk("noclr_busy", clear_busy, 0);
    chk("noclr_we", ram_we, 1);
    chk("noclr_x", ram_x, 3);
    step();
`endif

    // ---- reset during a write ----
    do_reset();
    blank = 1; req0_valid = 1; req0_x = 77; req0_y = 88; req0_data = 1;
    step();
    req0_valid = 0;
    chk("mid_we_before", ram_we, 1);
    rst = 1;
    #1;
    chk("mid_we", ram_we, 0);
    chk("mid_x", ram_x, 0);
    chk("mid_y", ram_y, 0);
    chk("mid_wdata", ram_wdata, 0);
    chk("mid_err", err_drop, 0);
    step();
    rst = 0;
    req0_valid = 1; req0_x = 1; req1_valid = 1; req1_x = 2;
    #1;
    chk("mid_first_rdy0", req0_ready, 1);
    chk("mid_first_rdy1", req1_ready, 0);
    step();
    idle_inputs();
    step();

    // ---- WR_CYCLES=3: blank dropping mid-write still gives 3 write cycles ----
    do_reset();
    blank = 1; req0_valid = 1; req0_x = 7; req0_y = 9; req0_data = 1;
    #1;
    chk("w3_rdy0", w3_req0_ready, 1);
    step();
    req0_valid = 0; blank = 0;
    for (int i = 0; i < 3; i++) begin
      chk("w3_we_hi", w3_we, 1);
      chk("w3_x", w3_x, 7);
      step();
    end
    chk("w3_we_lo", w3_we, 0);
    req1_valid = 1; req1_x = 8;
    #1;
    chk("w3_gate_rdy1", w3_req1_ready, 0);
    blank = 1;
    #1;
    chk("w3_reopen_rdy1", w3_req1_ready, 1);
    step();
    idle_inputs();
    step();

`ifdef VGA_CLEAR_EN
    // ---- framebuffer clear with a 10-cycle blank gap ----
    begin
      int busy_cnt;
      int we_cnt;
      int cyc;
      logic [9:0] lx, ly;
      logic lw;
      busy_cnt = 0; we_cnt = 0; cyc = 0; lx = 0; ly = 0; lw = 1;
      do_reset();
      blank = 1; clear_start = 1; req0_valid = 1; req0_x = 1;
      #1;
      chk("clr_pre_rdy0", req0_ready, 0);
      step();
      clear_start = 0; req0_valid = 0;
      while (clear_busy && cyc < 400000) begin
        busy_cnt++;
        if (ram_we) begin
          we_cnt++; lx = ram_x; ly = ram_y; lw = ram_wdata;
        end
        blank = (cyc >= 1000 && cyc < 1010) ? 1'b0 : 1'b1;
        cyc++;
        step();
      end
      chk("clr_busy_cycles", busy_cnt, 307210);
      chk("clr_we_cycles", we_cnt, 307200);
      chk("clr_last_x", lx, 639);
      chk("clr_last_y", ly, 479);
      chk("clr_last_wdata", lw, 0);
      chk("clr_end_x", ram_x, 0);
      chk("clr_end_we", ram_we, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_ram_write_arbiter.md
Name: vga_ram_write_arbiter

Overview:
- Shares the single-bit video RAM write port (write_enable, write_data, xcoor/ycoor) of the VGA RAM display between two requesters.
- Requester 0 is the host/loader; requester 1 is the game-logic updater.
- Writes are issued only while the sync generator reports blanking, so pixel fetches are never disturbed.
- Uses valid/ready handshakes with round-robin priority, drops out-of-range coordinates, and can optionally sequence a full-framebuffer clear.

Parameters:
- X_W, 10, x coordinate width
- Y_W, 10, y coordinate width
- X_MAX, 639, last valid x
- Y_MAX, 479, last valid y
- WR_CYCLES, 1, cycles ram_we is held per write (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- blank  in  1  1 = write window open (display inactive)
- req0_valid  in  1  requester 0 has a pixel write
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req0_x  in  X_W  requester 0 x
- req0_y  in  Y_W  requester 0 y
- req0_data  in  1  requester 0 pixel bit
- req1_valid, req1_ready, req1_x, req1_y, req1_data  same as requester 0, for requester 1
- clear_start  in  1  pulse: begin framebuffer clear
- clear_busy  out  1  clear sweep in progress
- ram_we  out  1  to RAM write_enable
- ram_x  out  X_W  to RAM write x
- ram_y  out  Y_W  to RAM write y
- ram_wdata  out  1  to RAM write_data
- err_drop  out  1  one-cycle pulse: out-of-range request discarded

Behaviour:
- Reset: asynchronous, active-high.
  - ram_we=0, ram_x=0, ram_y=0, ram_wdata=0, err_drop=0, clear_busy=0.
  - State=IDLE; round-robin pointer last=1, so requester 0 wins first.
  - Reset asserted mid-write drops ram_we immediately.
- States: IDLE, WRITE, CLEAR (CLEAR only with VGA_CLEAR_EN).
- reqN_ready is combinational: state==IDLE && blank && reqN_valid && sel==N.
  - sel = the sole valid requester.
  - If both are valid, sel = the requester not equal to last.
- A transfer is valid && ready. On a transfer:
  - Capture x/y/data into ram_x/ram_y/ram_wdata.
  - last <= sel.
  - If in range: go to WRITE.
  - If x>X_MAX or y>Y_MAX: pulse err_drop for the next cycle, no write, stay IDLE.
- WRITE:
  - ram_we=1 for exactly WR_CYCLES cycles, starting the cycle after the transfer, then return to IDLE.
  - ram_x/y/wdata are stable throughout.
  - Throughput: at most one write per WR_CYCLES+1 cycles.
- blank falling during WRITE: the write still completes. No new transfer until blank is 1 again.
- blank low: both ready outputs are 0 and requests wait. Requesters hold valid and payload until accepted.
- ram_x/ram_y/ram_wdata retain their last values when ram_we=0.
- Simultaneous clear_start and a valid request in IDLE: clear wins.

Optional Feature:
- Macro VGA_CLEAR_EN.
- Defined:
  - clear_start in IDLE enters CLEAR and sets clear_busy=1.
  - Counters sweep x 0..X_MAX in the inner loop and y 0..Y_MAX in the outer loop.
  - One pixel per cycle with ram_we=1, ram_wdata=0, only while blank=1. The sweep pauses (ram_we=0, counters held) while blank=0.
  - After the write of (X_MAX,Y_MAX): return to IDLE, clear_busy=0, ram_x/y wrap to 0.
  - Both ready outputs are 0 throughout the clear.
  - clear_start is ignored while in CLEAR or WRITE.
- Not defined: clear_start is ignored, clear_busy is tied 0, and there is no CLEAR state.

Test Plan:
- Single write: blank=1, req0 valid x=130 y=50 data=1.
  - req0_ready=1 that cycle.
  - Next cycle ram_we=1, ram_x=130, ram_y=50, ram_wdata=1, for 1 cycle.
- Contention: both valid continuously, blank=1, 4 transfers.
  - Grant order is 0,1,0,1.
  - ram_we pulses every 2 cycles.
- Blank gating: req1 valid with blank=0 for 20 cycles.
  - req1_ready=0 and ram_we=0 throughout.
  - Raising blank gives ready the same cycle.
  - Separately, dropping blank during a WR_CYCLES=3 write still yields 3 ram_we cycles.
- Out of range: req0 x=640 y=10.
  - req0_ready=1, err_drop=1 on the next cycle, ram_we stays 0.
- Reset mid-write: rst=1 while ram_we=1.
  - ram_we=0 immediately; all outputs at reset values.
  - After release, requester 0 wins the first contention.
- Clear (VGA_CLEAR_EN): clear_start with blank=1.
  - clear_busy stays high for exactly 307200 cycles, with ram_we high each cycle.
  - Last write is at (639,479), wdata=0.
  - A 10-cycle blank=0 gap extends the sweep by 10 cycles.
